// File: rtl/display_page_arbiter.sv
// Display page arbiter: picks which page word drives the tube display, debounces page/ack
// buttons and overlays blinking timed alerts. Define AUTO_CYCLE_EN for idle page rotation.
module display_page_arbiter #(
  parameter int          CLK_HZ       = 100_000_000,
  parameter int          DB_CYCLES    = 1_000_000,
  parameter int          BLINK_CYCLES = 25_000_000,
  parameter int          ALERT_SEC    = 10,
  parameter int          CYCLE_SEC    = 5,
  parameter logic [31:0] BLANK_WORD   = 32'hFFFF_FFFF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_next,
  input  logic         btn_ack,
  input  logic [127:0] page_data,
  input  logic [3:0]   alert_req,
  output logic [31:0]  disp_data,
  output logic [1:0]   cur_page,
  output logic [3:0]   page_led,
  output logic         alert_led
);

  localparam int DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int SEC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BL_W  = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int AS_W  = $clog2(ALERT_SEC + 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(CLK_HZ - 1);
  localparam logic [BL_W-1:0]  BL_LAST  = BL_W'(BLINK_CYCLES - 1);
  localparam logic [AS_W-1:0]  AS_LAST  = AS_W'(ALERT_SEC - 1);

  typedef enum logic {ST_NORMAL = 1'b0, ST_ALERT = 1'b1} state_t;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    case (idx)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0010;
      2'd2:    return 4'b0100;
      2'd3:    return 4'b1000;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic logic [1:0] lowest4(input logic [3:0] p);
    if (p[0])      return 2'd0;
    else if (p[1]) return 2'd1;
    else if (p[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  state_t            r_state, w_state_nx;
  logic [1:0]        r_cur_page, w_cur_nx, r_alert_page, w_apage_nx;
  logic [3:0]        r_pending, w_pend_nx, w_set, w_clr, r_page_led, w_led_nx;
  logic [31:0]       r_disp, w_disp_nx;
  logic              r_alert_led;
  logic [DB_W-1:0]   r_db_cnt;
  logic              r_next_smp, r_ack_smp, r_ev_next, r_ev_ack;
  logic [SEC_W-1:0]  r_sec_cnt, w_sec_nx;
  logic [AS_W-1:0]   r_alert_sec, w_asec_nx;
  logic [BL_W-1:0]   r_blink_cnt, w_bcnt_nx;
  logic              r_blink_on, w_bon_nx;
  logic              w_db_wrap, w_tick, w_retrig, w_timeout;
`ifdef AUTO_CYCLE_EN
  localparam int ID_W = $clog2(CYCLE_SEC + 1);
  logic [ID_W-1:0]   r_idle, w_idle_nx;
`endif

  assign w_db_wrap = (r_db_cnt == DB_LAST);
  assign w_tick    = (r_sec_cnt == SEC_LAST);
  assign w_retrig  = (r_state == ST_ALERT) && ((alert_req & onehot4(r_alert_page)) != 4'b0000);
  assign w_timeout = w_tick && !w_retrig && (r_alert_sec == AS_LAST);

  // Button sampler: edges are detected only between consecutive sample instants
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_cnt   <= '0;
      r_next_smp <= 1'b0;
      r_ack_smp  <= 1'b0;
      r_ev_next  <= 1'b0;
      r_ev_ack   <= 1'b0;
    end else if (w_db_wrap) begin
      r_db_cnt   <= '0;
      r_next_smp <= btn_next;
      r_ack_smp  <= btn_ack;
      r_ev_next  <= btn_next & ~r_next_smp;
      r_ev_ack   <= btn_ack & ~r_ack_smp;
    end else begin
      r_db_cnt   <= r_db_cnt + DB_W'(1);
      r_ev_next  <= 1'b0;
      r_ev_ack   <= 1'b0;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cur_nx   = r_cur_page;
    w_apage_nx = r_alert_page;
    w_sec_nx   = w_tick ? '0 : r_sec_cnt + SEC_W'(1);
    w_asec_nx  = r_alert_sec;
    w_bcnt_nx  = r_blink_cnt;
    w_bon_nx   = r_blink_on;
    w_disp_nx  = r_disp;
    w_set      = alert_req;
    w_clr      = 4'b0000;
`ifdef AUTO_CYCLE_EN
    w_idle_nx  = r_idle;
`endif
    case (r_state)
      ST_NORMAL: begin
        w_disp_nx = page_data[{r_cur_page, 5'b00000} +: 32];
`ifdef AUTO_CYCLE_EN
        if (r_ev_next) begin
          w_cur_nx  = r_cur_page + 2'd1;
          w_idle_nx = '0;
        end else if (w_tick) begin
          if (r_idle == ID_W'(CYCLE_SEC - 1)) begin
            w_cur_nx  = r_cur_page + 2'd1;
            w_idle_nx = '0;
          end else begin
            w_idle_nx = r_idle + ID_W'(1);
          end
        end else begin
          w_idle_nx = r_idle;
        end
`else
        if (r_ev_next) begin
          w_cur_nx = r_cur_page + 2'd1;
        end else begin
          w_cur_nx = r_cur_page;
        end
`endif
        if (r_pending != 4'b0000) begin
          w_state_nx = ST_ALERT;
          w_apage_nx = lowest4(r_pending);
          w_clr      = onehot4(lowest4(r_pending));
          w_sec_nx   = '0;
          w_asec_nx  = '0;
          w_bcnt_nx  = '0;
          w_bon_nx   = 1'b1;
        end else begin
          w_state_nx = ST_NORMAL;
        end
      end
      ST_ALERT: begin
        w_disp_nx = r_blink_on ? page_data[{r_alert_page, 5'b00000} +: 32] : BLANK_WORD;
        w_set     = alert_req & ~onehot4(r_alert_page);
        if (r_blink_cnt == BL_LAST) begin
          w_bcnt_nx = '0;
          w_bon_nx  = ~r_blink_on;
        end else begin
          w_bcnt_nx = r_blink_cnt + BL_W'(1);
        end
        // A retrigger of the shown page restarts the whole second timebase
        if (w_retrig) begin
          w_asec_nx = '0;
          w_sec_nx  = '0;
        end else if (w_tick) begin
          w_asec_nx = r_alert_sec + AS_W'(1);
        end else begin
          w_asec_nx = r_alert_sec;
        end
        if (r_ev_ack || r_ev_next || w_timeout) begin
          w_state_nx = ST_NORMAL;
`ifdef AUTO_CYCLE_EN
          w_idle_nx  = '0;
`endif
        end else begin
          w_state_nx = ST_ALERT;
        end
      end
      default: begin
        w_state_nx = ST_NORMAL;
      end
    endcase
    w_pend_nx = (r_pending & ~w_clr) | w_set;
    w_led_nx  = onehot4((w_state_nx == ST_ALERT) ? w_apage_nx : w_cur_nx);
  end

  // State, page selection, timers and registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_NORMAL;
      r_cur_page   <= 2'd0;
      r_alert_page <= 2'd0;
      r_pending    <= 4'b0000;
      r_disp       <= 32'h0000_0000;
      r_page_led   <= 4'b0001;
      r_alert_led  <= 1'b0;
      r_sec_cnt    <= '0;
      r_alert_sec  <= '0;
      r_blink_cnt  <= '0;
      r_blink_on   <= 1'b0;
`ifdef AUTO_CYCLE_EN
      r_idle       <= '0;
`endif
    end else begin
      r_state      <= w_state_nx;
      r_cur_page   <= w_cur_nx;
      r_alert_page <= w_apage_nx;
      r_pending    <= w_pend_nx;
      r_disp       <= w_disp_nx;
      r_page_led   <= w_led_nx;
      r_alert_led  <= (w_state_nx == ST_ALERT);
      r_sec_cnt    <= w_sec_nx;
      r_alert_sec  <= w_asec_nx;
      r_blink_cnt  <= w_bcnt_nx;
      r_blink_on   <= w_bon_nx;
`ifdef AUTO_CYCLE_EN
      r_idle       <= w_idle_nx;
`endif
    end
  end

  assign disp_data = r_disp;
  assign cur_page  = r_cur_page;
  assign page_led  = r_page_led;
  assign alert_led = r_alert_led;

endmodule

// File: tb/tb_display_page_arbiter.sv
// Randomized bench for display_page_arbiter against a cycle-count based reference model.
module tb_display_page_arbiter;

  localparam int CLK_HZ = 10;
  localparam int DB     = 2;
  localparam int BLINK  = 3;
  localparam int ASEC   = 2;
  localparam int CSEC   = 3;
  localparam logic [31:0] BLANK = 32'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst, btn_next, btn_ack;
  logic [3:0]   alert_req;
  logic [127:0] page_data;
  logic [31:0]  disp_data;
  logic [1:0]   cur_page;
  logic [3:0]   page_led;
  logic         alert_led;

  always #5 clk = ~clk;

  function automatic logic [31:0] pg(input int i);
    return 32'h1111_1111 * (i + 1);
  endfunction

  assign page_data = {pg(3), pg(2), pg(1), pg(0)};

  display_page_arbiter #(
    .CLK_HZ(CLK_HZ), .DB_CYCLES(DB), .BLINK_CYCLES(BLINK),
    .ALERT_SEC(ASEC), .CYCLE_SEC(CSEC), .BLANK_WORD(BLANK)
  ) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .btn_ack(btn_ack),
    .page_data(page_data), .alert_req(alert_req), .disp_data(disp_data),
    .cur_page(cur_page), .page_led(page_led), .alert_led(alert_led)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: timing expressed as cycle counts since reset / alert entry
  int       m_cyc, m_sec_base, m_alert_start, m_asecs, m_idle, m_page, m_apage;
  bit       m_alert, m_smp_n, m_smp_a, m_ev_n, m_ev_a;
  bit [3:0] m_pend;
  logic [31:0] m_disp;

  task automatic model_step(input bit rs, input bit bn, input bit ba, input bit [3:0] rq);
    bit tick, wrap, ev_n, ev_a, retrig;
    bit [3:0] set;
    int lo;
    if (rs) begin
      m_cyc = 0; m_sec_base = 0; m_alert_start = 0; m_asecs = 0; m_idle = 0;
      m_page = 0; m_apage = 0; m_alert = 0; m_pend = 4'b0000; m_disp = 32'h0;
      m_smp_n = 0; m_smp_a = 0; m_ev_n = 0; m_ev_a = 0;
      return;
    end
    tick = (((m_cyc - m_sec_base) % CLK_HZ) == CLK_HZ - 1);
    wrap = ((m_cyc % DB) == DB - 1);
    ev_n = m_ev_n;
    ev_a = m_ev_a;
    m_ev_n = wrap && bn && !m_smp_n;
    m_ev_a = wrap && ba && !m_smp_a;
    if (wrap) begin
      m_smp_n = bn;
      m_smp_a = ba;
    end
    set = rq;
    if (!m_alert) begin
      m_disp = pg(m_page);
      if (ev_n) begin
        m_page = (m_page + 1) % 4;
        m_idle = 0;
      end
`ifdef AUTO_CYCLE_EN
      else if (tick) begin
        m_idle++;
        if (m_idle == CSEC) begin
          m_page = (m_page + 1) % 4;
          m_idle = 0;
        end
      end
`endif
      if (m_pend != 4'b0000) begin
        lo = 0;
        for (int i = 3; i >= 0; i--) if (m_pend[i]) lo = i;
        m_pend[lo] = 1'b0;
        m_apage = lo;
        m_alert = 1;
        m_sec_base = m_cyc + 1;
        m_alert_start = m_cyc + 1;
        m_asecs = 0;
      end
    end else begin
      m_disp = ((((m_cyc - m_alert_start) / BLINK) % 2) == 0) ? pg(m_apage) : BLANK;
      retrig = rq[m_apage];
      set[m_apage] = 1'b0;
      if (tick) m_asecs++;
      if (retrig) begin
        m_asecs = 0;
        m_sec_base = m_cyc + 1;
      end
      if (ev_a || ev_n || m_asecs >= ASEC) begin
        m_alert = 0;
        m_idle = 0;
      end
    end
    m_pend |= set;
    m_cyc++;
  endtask

  task automatic run_cycle(input bit rs, input bit bn, input bit ba, input bit [3:0] rq);
    logic [3:0] exp_led;
    @(negedge clk);
    exp_led = 4'b0001 << (m_alert ? m_apage : m_page);
    check("disp_data", disp_data, m_disp);
    check("cur_page", 32'(cur_page), 32'(m_page));
    check("page_led", 32'(page_led), 32'(exp_led));
    check("alert_led", 32'(alert_led), 32'(m_alert));
    rst = rs; btn_next = bn; btn_ack = ba; alert_req = rq;
    @(posedge clk);
    model_step(rs, bn, ba, rq);
  endtask

  task automatic idle(input int n);
    repeat (n) run_cycle(1'b0, 1'b0, 1'b0, 4'b0000);
  endtask

  initial begin
    bit bn, ba, rs;
    bit [3:0] rq;
    int saved_page;
    rst = 1'b1; btn_next = 1'b0; btn_ack = 1'b0; alert_req = 4'b0000;
    @(posedge clk);
    model_step(1'b1, 1'b0, 1'b0, 4'b0000);
    run_cycle(1'b1, 1'b0, 1'b0, 4'b0000);
    #1;
    check("rst_disp", disp_data, 32'h0);
    check("rst_page", 32'(cur_page), 32'd0);
    check("rst_led", 32'(page_led), 32'h1);
    check("rst_alert", 32'(alert_led), 32'd0);

    for (int i = 0; i < 4; i++) begin
      repeat (10) run_cycle(1'b0, 1'b1, 1'b0, 4'b0000);
      idle(10);
      #1;
      check("sw_page", 32'(cur_page), 32'((i + 1) % 4));
      check("sw_disp", disp_data, pg((i + 1) % 4));
      check("sw_led", 32'(page_led), 32'(1 << ((i + 1) % 4)));
    end

    run_cycle(1'b0, 1'b0, 1'b0, 4'b0100);
    idle(1);  #1; check("alert_enter", 32'(alert_led), 32'd1);
    idle(1);  #1; check("blink_on", disp_data, 32'h3333_3333);
    idle(3);  #1; check("blink_off", disp_data, 32'hFFFF_FFFF);
    idle(15); #1; check("alert_hold", 32'(alert_led), 32'd1);
    idle(1);  #1; check("alert_timeout", 32'(alert_led), 32'd0);
    idle(1);  #1; check("post_disp", disp_data, 32'h1111_1111);
    check("post_page", 32'(cur_page), 32'd0);

    run_cycle(1'b0, 1'b0, 1'b0, 4'b1010);
    idle(1); #1; check("q_first", 32'(page_led), 32'b0010);
    repeat (6) run_cycle(1'b0, 1'b0, 1'b1, 4'b0000);
    idle(6); #1;
    check("q_second", 32'(page_led), 32'b1000);
    check("q_second_on", 32'(alert_led), 32'd1);
    repeat (6) run_cycle(1'b0, 1'b0, 1'b1, 4'b0000);
    idle(25); #1; check("q_done", 32'(alert_led), 32'd0);

    run_cycle(1'b0, 1'b0, 1'b0, 4'b0001);
    idle(3); #1; check("dis_pre", 32'(alert_led), 32'd1);
    saved_page = m_page;
    repeat (6) run_cycle(1'b0, 1'b1, 1'b0, 4'b0000);
    idle(6); #1;
    check("dis_led", 32'(alert_led), 32'd0);
    check("dis_page", 32'(cur_page), 32'(saved_page));

    run_cycle(1'b0, 1'b0, 1'b0, 4'b0100);
    idle(15);
    run_cycle(1'b0, 1'b0, 1'b0, 4'b0100);
    idle(19); #1; check("retrig_hold", 32'(alert_led), 32'd1);
    idle(1);  #1; check("retrig_exit", 32'(alert_led), 32'd0);

    run_cycle(1'b0, 1'b0, 1'b0, 4'b1001);
    idle(3);
    run_cycle(1'b1, 1'b0, 1'b0, 4'b0000);
    #1;
    check("mid_rst_alert", 32'(alert_led), 32'd0);
    check("mid_rst_page", 32'(cur_page), 32'd0);
    check("mid_rst_led", 32'(page_led), 32'h1);
    check("mid_rst_disp", disp_data, 32'h0);
    idle(40); #1; check("mid_rst_quiet", 32'(alert_led), 32'd0);

    run_cycle(1'b1, 1'b0, 1'b0, 4'b0000);
    idle(200); #1;
`ifdef AUTO_CYCLE_EN
    check("auto_page", 32'(cur_page), 32'd2);
`else
    check("auto_page", 32'(cur_page), 32'd0);
`endif

    bn = 1'b0; ba = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) bn = ~bn;
      if ($urandom_range(0, 9) == 0) ba = ~ba;
      rq = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      rs = ($urandom_range(0, 299) == 0);
      run_cycle(rs, bn, ba, rq);
    end
    idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
